// File: rtl/ppu_pkg.sv
// Shared types, screen constants and the bounding-box compare used by the
// pixel processing unit object renderers.
package ppu_pkg;

   typedef logic [23:0] rgb_t;
   typedef rgb_t sprite_mem_t [0:255];

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam int SPRITE_SIZE = 16;

   localparam rgb_t COLOR_WHITE = 24'hFFFFFF;
   localparam rgb_t COLOR_BLACK = 24'h000000;
   localparam rgb_t KEY_COLOR = 24'hFF00FF;

   // Eleven bits so that start + len never wraps for any 10-bit start.
   function automatic logic in_bbox(
      input logic [10:0] p,
      input logic [10:0] s,
      input logic [10:0] len
   );
      return (p >= s) && (p < s + len);
   endfunction

endpackage

// File: rtl/draw_square.sv
// Solid white square of programmable edge length, registered one cycle
// after the scan coordinate.
module draw_square
   import ppu_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] x,
   input  logic [8:0] y,
   input  logic [9:0] xStart,
   input  logic [8:0] yStart,
   input  logic [4:0] length,
   output logic       draw,
   output rgb_t       color
);

   logic hit;

   always_comb begin
      hit = in_bbox({1'b0, x}, {1'b0, xStart}, {6'd0, length})
         && in_bbox({2'b0, y}, {2'b0, yStart}, {6'd0, length});
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         draw  <= 1'b0;
         color <= COLOR_BLACK;
      end else begin
         draw  <= hit;
         color <= hit ? COLOR_WHITE : COLOR_BLACK;
      end
   end

endmodule

// File: rtl/draw_sprite.sv
// 16x16 sprite renderer: hit test plus sprite memory lookup with a
// transparent key colour, registered one cycle after the scan coordinate.
module draw_sprite
   import ppu_pkg::*;
#(
   parameter int   SIZE      = 16,
   parameter rgb_t KEY_COLOR = ppu_pkg::KEY_COLOR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [9:0]  x,
   input  logic [8:0]  y,
   input  logic [9:0]  xStart,
   input  logic [8:0]  yStart,
   input  sprite_mem_t sprite,
   output logic        draw,
   output rgb_t        color
);

   logic       hit;
   logic       opaque;
   logic [3:0] dx;
   logic [3:0] dy;
   rgb_t       pix;

   // Only the low nibble of each offset addresses the sprite memory.
   always_comb begin
      dx = x[3:0] - xStart[3:0];
      dy = y[3:0] - yStart[3:0];
      pix = sprite[{dy, dx}];
      hit = in_bbox({1'b0, x}, {1'b0, xStart}, 11'(SIZE))
         && in_bbox({2'b0, y}, {2'b0, yStart}, 11'(SIZE));
      opaque = hit && (pix != KEY_COLOR);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         draw  <= 1'b0;
         color <= COLOR_BLACK;
      end else begin
         draw  <= opaque;
         color <= opaque ? pix : COLOR_BLACK;
      end
   end

endmodule

// File: tb/tb_draw_sprite.sv
// Scoreboard bench for draw_sprite and its companion draw_square.
module tb_draw_sprite;
   import ppu_pkg::*;

   typedef struct packed {
      int   due;
      logic sq;
      logic d;
      rgb_t c;
   } exp_t;

   logic        clk;
   logic        reset;
   logic [9:0]  x;
   logic [8:0]  y;
   logic [9:0]  xs;
   logic [8:0]  ys;
   sprite_mem_t mem;
   logic        draw;
   rgb_t        color;

   logic [9:0]  qx;
   logic [8:0]  qy;
   logic [9:0]  qxs;
   logic [8:0]  qys;
   logic [4:0]  qlen;
   logic        qdraw;
   rgb_t        qcolor;

   int   cyc;
   int   checks;
   int   errors;
   exp_t q[$];
   string names[$];

   draw_sprite dut (
      .clk(clk),
      .reset(reset),
      .x(x),
      .y(y),
      .xStart(xs),
      .yStart(ys),
      .sprite(mem),
      .draw(draw),
      .color(color)
   );

   draw_square sq (
      .clk(clk),
      .reset(reset),
      .x(qx),
      .y(qy),
      .xStart(qxs),
      .yStart(qys),
      .length(qlen),
      .draw(qdraw),
      .color(qcolor)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string n, input logic d, input rgb_t c,
                        input logic ed, input rgb_t ec);
      checks++;
      if (d !== ed || c !== ec) begin
         errors++;
         $display("FAIL %s: got draw=%0b color=%06h, want draw=%0b color=%06h",
                  n, d, c, ed, ec);
      end
   endtask

   always @(negedge clk) begin
      while (q.size() > 0 && q[0].due == cyc) begin
         exp_t e;
         string n;
         e = q.pop_front();
         n = names.pop_front();
         if (e.sq) check(n, qdraw, qcolor, e.d, e.c);
         else check(n, draw, color, e.d, e.c);
      end
   end

   task automatic spr(input string n, input logic [9:0] px,
                      input logic [8:0] py, input logic ed, input rgb_t ec);
      exp_t e;
      @(negedge clk);
      x = px;
      y = py;
      e.due = cyc + 1;
      e.sq = 1'b0;
      e.d = ed;
      e.c = ec;
      q.push_back(e);
      names.push_back(n);
   endtask

   task automatic sqr(input string n, input logic [9:0] px,
                      input logic [8:0] py, input logic [4:0] len,
                      input logic ed, input rgb_t ec);
      exp_t e;
      @(negedge clk);
      qx = px;
      qy = py;
      qlen = len;
      e.due = cyc + 1;
      e.sq = 1'b1;
      e.d = ed;
      e.c = ec;
      q.push_back(e);
      names.push_back(n);
   endtask

   task automatic drain;
      int budget;
      budget = 0;
      while (q.size() > 0 && budget < 10) begin
         @(posedge clk);
         budget++;
      end
      @(negedge clk);
      #1;
      if (q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending, want 0", q.size());
         q.delete();
         names.delete();
      end
   endtask

   initial begin
      cyc = 0;
      checks = 0;
      errors = 0;
      for (int i = 0; i < 256; i++) mem[i] = {8'h10, 8'(i), 8'(i)};
      mem[0] = 24'h123456;
      mem[17] = 24'hFF00FF;
      x = 10'd0;
      y = 9'd0;
      xs = 10'd100;
      ys = 9'd50;
      qx = 10'd0;
      qy = 9'd0;
      qxs = 10'd5;
      qys = 9'd300;
      qlen = 5'd6;
      reset = 1'b1;
      #1 reset = 1'b0;
      #2;
      check("reset_spr", draw, color, 1'b0, 24'h0);
      check("reset_sq", qdraw, qcolor, 1'b0, 24'h0);
      @(negedge clk);
      reset = 1'b1;

      spr("spr_hit", 10'd100, 9'd50, 1'b1, 24'h123456);
      spr("spr_idx1", 10'd101, 9'd50, 1'b1, 24'h100101);
      spr("spr_last", 10'd115, 9'd65, 1'b1, 24'h10FFFF);
      spr("spr_right", 10'd116, 9'd50, 1'b0, 24'h0);
      spr("spr_below", 10'd100, 9'd66, 1'b0, 24'h0);
      spr("spr_left", 10'd99, 9'd50, 1'b0, 24'h0);
      spr("spr_key", 10'd101, 9'd51, 1'b0, 24'h0);
      drain();

      sqr("sq_corner", 10'd5, 9'd300, 5'd6, 1'b1, 24'hFFFFFF);
      sqr("sq_far", 10'd10, 9'd305, 5'd6, 1'b1, 24'hFFFFFF);
      sqr("sq_right", 10'd11, 9'd300, 5'd6, 1'b0, 24'h0);
      sqr("sq_left", 10'd4, 9'd300, 5'd6, 1'b0, 24'h0);
      sqr("sq_below", 10'd5, 9'd306, 5'd6, 1'b0, 24'h0);
      sqr("sq_len0", 10'd5, 9'd300, 5'd0, 1'b0, 24'h0);
      sqr("sq_len0b", 10'd6, 9'd301, 5'd0, 1'b0, 24'h0);
      drain();

      @(negedge clk);
      xs = 10'd630;
      spr("clip_hit", 10'd639, 9'd50, 1'b1, 24'h100909);
      spr("clip_wrap", 10'd0, 9'd50, 1'b0, 24'h0);
      drain();

      @(negedge clk);
      xs = 10'd100;
      x = 10'd100;
      y = 9'd50;
      @(posedge clk);
      #2;
      check("pre_rst", draw, color, 1'b1, 24'h123456);
      reset = 1'b0;
      #1;
      check("async_rst", draw, color, 1'b0, 24'h0);
      @(posedge clk);
      #1;
      check("held_rst", draw, color, 1'b0, 24'h0);
      @(negedge clk);
      reset = 1'b1;
      spr("post_rst", 10'd115, 9'd65, 1'b1, 24'h10FFFF);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/draw_sprite.md
# draw_sprite

Per-pixel object renderer for the pixel processing unit. The VGA driver scans coordinates (x, y). For each one, draw_sprite reports whether a 16x16 sprite placed at (xStart, yStart) covers that pixel, and if so its 24-bit colour, read from a sprite memory. The companion sub-module draw_square does the same for a solid white square of programmable size. Both outputs feed the sprite encoder, which picks one object per pixel.

## Interface
Parameters:
- SIZE, 16: sprite edge length in pixels; the sprite memory holds SIZE*SIZE words.
- KEY_COLOR, 24'hFF00FF: transparent colour; pixels of this colour are not drawn.

Ports (draw_sprite):
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-low reset
- x  in  10  current scan column, 0..639
- y  in  9  current scan row, 0..479
- xStart  in  10  sprite left edge
- yStart  in  9  sprite top edge
- sprite  in  24 x 256 (unpacked)  RGB888 sprite data, row-major, index = row*16 + col
- draw  out  1  the sprite covers (x, y) with an opaque pixel
- color  out  24  RGB888 colour of that pixel

Ports (draw_square): clk, reset, x, y, xStart, yStart as above; length in 5 (edge length in pixels); draw out 1; color out 24.

## Operation
- Offsets: dx = x − xStart and dy = y − yStart, computed 11 bits wide, unsigned.
- Hit test, evaluated with xStart+SIZE and yStart+SIZE in 11 bits so the sum never wraps:
  - xStart ≤ x < xStart+SIZE
  - yStart ≤ y < yStart+SIZE
- Sprite pixel: pix = sprite[dy[3:0]*16 + dx[3:0]].
- Sprite outputs:
  - draw = hit && (pix != KEY_COLOR)
  - color = pix when draw is 1, otherwise 24'h000000.
- Square hit test: xStart ≤ x < xStart+length and yStart ≤ y < yStart+length. When hit, color = 24'hFFFFFF; otherwise draw = 0 and color = 0.
- length = 0: the square never draws.
- Clipping: a sprite or square placed partly past 639/479 is clipped naturally, because those coordinates are never scanned. Nothing wraps to the opposite edge.
- xStart, yStart and length may change on any cycle. The new value takes effect on the next registered output; no handshake is used.

## Timing
- draw and color are registered on the rising edge of clk.
- Latency is exactly 1 cycle: the outputs at cycle n+1 describe the (x, y) present at cycle n.
- Reset asserted (low): draw = 0 and color = 24'h000000 immediately, without waiting for a clock edge.
- Reset deasserted: the first valid output follows the next rising edge.
- Reset asserted mid-frame: outputs clear at once. After release, operation resumes at the current scan position with no other state to recover.
- Both modules are fully pipelined: one pixel per clock and no stalls.

## Structure
- Shared package ppu_pkg:
  - typedef rgb_t (logic [23:0])
  - constants SCREEN_W = 640, SCREEN_H = 480, SPRITE_SIZE = 16, COLOR_WHITE, COLOR_BLACK, KEY_COLOR
  - typedef sprite_mem_t (rgb_t [0:255])
- One sub-module, draw_square: a separate module using the same bounding-box compare, with a constant colour.
- A bbox compare function in ppu_pkg is shared by both modules.

## Test plan
- Sprite hit: xStart = 100, yStart = 50, sprite[0] = 24'h123456; x = 100, y = 50 → next cycle draw = 1, color = 24'h123456.
- Sprite indexing and edges, with the sprite at (100, 50):
  - x = 115, y = 65 → color = sprite[255].
  - x = 116 or y = 66 → draw = 0, color = 0.
  - x = 99 → draw = 0.
- Transparency: a pixel at index 17 set to 24'hFF00FF; x = 101, y = 51 → draw = 0, color = 0.
- Square, xStart = 5, yStart = 300, length = 6:
  - (5, 300) → draw = 1, color = 24'hFFFFFF.
  - (10, 305) → draw = 1.
  - (11, 300) → draw = 0.
  - length = 0 → draw = 0 everywhere.
- Edge clip: xStart = 630, x = 639 → draw = 1, color = sprite[9]; x = 0 → draw = 0 (no wrap).
- Async reset: drive a hit, then pull reset low between clock edges → draw = 0 and color = 0 before the next edge. Release reset → correct output one cycle later.
